// File: rtl/alu_mul_seq.sv
// Sequential radix-2 Booth multiplier that borrows a shared external ripple adder.
// One operation takes WIDTH RUN cycles plus a single DONE cycle.
//
// state | meaning
// IDLE  | waiting for start; adder drive parked at zero
// RUN   | one Booth add/subtract plus arithmetic right shift per cycle
// DONE  | one-cycle done pulse; hi/lo hold the product
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, q_q, m_q;
  logic             q1_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf, msb;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy  = 1'b1;
        add_a = a_q;
        case ({q_q[0], q1_q})
          2'b01: add_b = m_q;
          2'b10: begin
            add_b   = ~m_q;
            add_cin = 1'b1;
          end
          default: ;
        endcase
        if (cnt_q == LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Correct the sign bit on signed overflow so M = -2^(WIDTH-1) stays exact.
  assign ovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_s[WIDTH-1] != add_a[WIDTH-1]);
  assign msb = add_s[WIDTH-1] ^ ovf;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      q1_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m_q   <= ra;
          q_q   <= rb;
          a_q   <= '0;
          q1_q  <= 1'b0;
          cnt_q <= '0;
        end
        RUN: begin
          a_q   <= {msb, add_s[WIDTH-1:1]};
          q_q   <= {add_s[0], q_q[WIDTH-1:1]};
          q1_q  <= q_q[0];
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign hi = a_q;
  assign lo = q_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed corner cases plus random operands
// compared against a plain signed 64-bit multiply.
module tb_alu_mul_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] ra = '0, rb = '0;
  logic         busy, done, add_cin;
  logic [W-1:0] hi, lo, add_a, add_b, add_s;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  // Shared ripple adder lives outside the multiplier.
  assign add_s = add_a + add_b + W'(add_cin);

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .ra(ra), .rb(rb),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  // Launch one operation, scramble ra/rb right after the load edge, wait for done.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] prod, output int lat, output int bcnt);
    @(negedge clk);
    ra = x; rb = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ra = $urandom; rb = $urandom;
    lat = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    prod = {hi, lo};
  endtask

  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp);
    logic [63:0] prod;
    int lat, bcnt;
    run_op(x, y, prod, lat, bcnt);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_busy"}, 64'(bcnt), 64'd32);
    chk({tag, "_prod"}, prod, exp);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold"}, {hi, lo}, exp);
    chk({tag, "_nodone"}, 64'(done), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    int cyc, nd, dcyc, last;
    logic [31:0] dlo, dhi;

    // Reset state while clr_n is held low
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_adda", 64'(add_a), 64'd0);
    chk("rst_addb", 64'(add_b), 64'd0);
    chk("rst_cin",  64'(add_cin), 64'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;

    do_op("m6x7",  32'd6, 32'd7, 64'h0000_0000_0000_002A);
    do_op("mn3x5", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op("mminmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    do_op("mminm1",  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    do_op("mmaxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, ref_mul(32'h7FFF_FFFF, 32'h7FFF_FFFF));
    do_op("mmaxmin", 32'h7FFF_FFFF, 32'h8000_0000, ref_mul(32'h7FFF_FFFF, 32'h8000_0000));
    do_op("mzero",   32'h0, 32'h8000_0000, 64'd0);

    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 6 == 0) x = 32'h8000_0000;
      if (i % 8 == 1) y = 32'h8000_0000 | 32'(i);
      do_op($sformatf("rnd%0d", i), x, y, ref_mul(x, y));
    end

    // Second start during RUN must be ignored
    @(negedge clk);
    ra = 32'd6; rb = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; nd = 0; dcyc = 0; dlo = '0; dhi = '1;
    while (cyc < 90) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 9) begin ra = 32'd2; rb = 32'd2; start = 1'b1; end
      if (cyc == 10) start = 1'b0;
      if (done) begin nd++; dcyc = cyc; dlo = lo; dhi = hi; end
    end
    chk("ign_ndone", 64'(nd), 64'd1);
    chk("ign_cyc", 64'(dcyc), 64'd33);
    chk("ign_prod", {dhi, dlo}, 64'h2A);

    // Mid-RUN asynchronous clear
    @(negedge clk);
    ra = 32'd6; rb = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_hilo", {hi, lo}, 64'd0);
    chk("clr_add",  {add_a, add_b}, 64'd0);
    @(posedge clk); #3;
    clr_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("clr_noact", 64'(nd), 64'd0);
    do_op("post_clr", 32'd6, 32'd7, 64'h2A);

    // Start held high: back-to-back operations every 34 cycles
    @(negedge clk);
    ra = 32'hFFFF_FFFB; rb = 32'd9; start = 1'b1;
    nd = 0; last = 0;
    for (int c = 0; c < 156; c++) begin
      @(posedge clk); #1;
      if (!busy) begin
        chk($sformatf("cont_adda_%0d", c), 64'(add_a), 64'd0);
        chk($sformatf("cont_addb_%0d", c), 64'(add_b), 64'd0);
        chk($sformatf("cont_cin_%0d", c), 64'(add_cin), 64'd0);
      end
      if (done) begin
        if (nd > 0) chk("cont_space", 64'(c - last), 64'd34);
        chk("cont_prod", {hi, lo}, ref_mul(32'hFFFF_FFFB, 32'd9));
        last = c;
        nd++;
      end
    end
    chk("cont_ndone", 64'(nd), 64'd4);
    chk("cont_first", 64'(last - 3 * 34), 64'd32);
    start = 1'b0;
    repeat (40) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The module SHALL have parameter: WIDTH, 32, operand width in bits; the bench exercises 32 only.
REQ-002 The module SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 The module SHALL have port: clr_n  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have port: start  input  1  request to multiply ra by rb.
REQ-005 The module SHALL have port: ra  input  WIDTH  multiplicand, two's complement.
REQ-006 The module SHALL have port: rb  input  WIDTH  multiplier, two's complement.
REQ-007 The module SHALL have port: busy  output  1  high while in RUN.
REQ-008 The module SHALL have port: done  output  1  one-cycle pulse when hi/lo are valid.
REQ-009 The module SHALL have port: hi  output  WIDTH  upper half of the 2*WIDTH signed product.
REQ-010 The module SHALL have port: lo  output  WIDTH  lower half of the product.
REQ-011 The module SHALL have port: add_a  output  WIDTH  operand A to the shared external ripple adder.
REQ-012 The module SHALL have port: add_b  output  WIDTH  operand B to the shared adder.
REQ-013 The module SHALL have port: add_cin  output  1  carry-in to the shared adder.
REQ-014 The module SHALL have port: add_s  input  WIDTH  adder sum, combinational from add_a/add_b/add_cin.

Function
REQ-015 The module SHALL implement radix-2 Booth multiplication using the external adder for every partial-sum step; it SHALL contain no internal WIDTH-bit adder or subtractor except the iteration counter.
REQ-016 The module SHALL hold state {A[WIDTH], Q[WIDTH], q_1[1]}, a latched multiplicand M, and a count from 0 to WIDTH.
REQ-017 The FSM SHALL have states IDLE, RUN, DONE; reset state is IDLE.
REQ-018 In IDLE with start=1, the next edge SHALL load M=ra, Q=rb, A=0, q_1=0, count=0, and enter RUN; otherwise the FSM stays in IDLE.
REQ-019 In RUN, the adder drive SHALL follow {Q[0],q_1}: 01 -> add_a=A, add_b=M, add_cin=0; 10 -> add_a=A, add_b=~M, add_cin=1; 00/11 -> add_a=A, add_b=0, add_cin=0.
REQ-020 Each RUN edge SHALL arithmetic-shift {add_s,Q,q_1} right by one and increment count.
REQ-021 The shifted-in MSB SHALL be add_s[WIDTH-1] XOR ovf, where ovf=(add_a[MSB]==add_b[MSB]) AND (add_s[MSB]!=add_a[MSB]), so the case M=-2^(WIDTH-1) is exact.
REQ-022 After exactly WIDTH RUN cycles the FSM SHALL enter DONE, which lasts one cycle and then returns to IDLE.
REQ-023 The module SHALL assert done only in DONE and busy only in RUN.
REQ-024 hi/lo SHALL equal A/Q; they SHALL be valid from the DONE cycle and held unchanged until the next accepted start.
REQ-025 Latency SHALL be WIDTH+1 edges, with done high in the cycle after the WIDTH-th RUN edge; for WIDTH=32, done is high 33 cycles after the start edge.
REQ-026 The module SHALL ignore start in RUN and DONE, with no queuing; ra/rb changes after the load edge SHALL have no effect.
REQ-027 In IDLE and DONE, add_a, add_b and add_cin SHALL be 0.

Reset
REQ-028 While clr_n=0, independent of clk, the module SHALL force the FSM to IDLE and clear A, Q, q_1, M, count, busy, done, hi and lo to 0.
REQ-029 Assertion of clr_n mid-RUN SHALL abort the operation, and no done SHALL follow.
REQ-030 After clr_n deasserts, the first start SHALL be accepted normally.

Verification
REQ-031 The bench SHALL cover: ra=6, rb=7, start for 1 cycle -> busy for 32 cycles, then done pulse with hi=0x00000000, lo=0x0000002A.
REQ-032 The bench SHALL cover: ra=-3, rb=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 The bench SHALL cover: ra=0x80000000, rb=0x80000000 -> hi=0x40000000, lo=0x00000000; also ra=0x80000000, rb=0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.
REQ-034 The bench SHALL cover: start with 6x7, then at cycle 10 start with ra=2, rb=2 -> second start ignored; done at cycle 33 with lo=0x2A, and exactly one done pulse.
REQ-035 The bench SHALL cover: clr_n low for 1 cycle at RUN cycle 12 -> busy=0, hi=lo=0 immediately with no clk edge; no done; a subsequent 6x7 completes correctly.
REQ-036 The bench SHALL cover: start held high continuously -> a new operation every 34 cycles, done pulses spaced 34 cycles apart, and add_* = 0 in every IDLE and DONE cycle.
